// File: rtl/apb_regfile.sv
// APB completer holding NUM_REGS read/write registers of DATA_WIDTH bits, exposed to the local fabric.
// Latency: setup at T, pready in cycle T+1+WAIT_CYCLES; register update and reg_wr pulse in the following cycle.
// Backpressure: pready is the only stall; the wait-state count advances only while psel & penable are held.
//
// Ports:
//   pclk, presetn                : clock, asynchronous active-low reset
//   psel/penable/pwrite/paddr/
//   pwdata/pstrb/pprot           : APB request from the requester stage
//   pready/prdata/pslverr        : APB response (combinational from FSM state and count)
//   regs_q                       : flattened register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr                       : one-cycle pulse per register written
//
// Optional feature macro: APB_REGFILE_SECURE_EN
//   defined   -> transfers with pprot[1] = 1 (non-secure) complete with pslverr and have no effect
//   undefined -> pprot is ignored

module apb_regfile #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                           pclk,
    input  logic                           presetn,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    input  logic [2:0]                     pprot,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
    output logic [NUM_REGS-1:0]            reg_wr
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFS    = $clog2(STRB_W);
    localparam int WIDX_W = ADDR_WIDTH - OFS;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                 state;
    logic [3:0]             cnt;
    logic [IDX_W-1:0]       idx;
    logic                   wr;
    logic                   err;
    logic [DATA_WIDTH-1:0]  wdata;
    logic [STRB_W-1:0]      strb;
    logic [DATA_WIDTH-1:0]  regs [NUM_REGS];

    logic [WIDX_W-1:0]      word_idx;
    logic                   setup_err;
    logic                   unused_prot;

    // Only pprot[1] matters, and only in the secure build.
    assign unused_prot = ^pprot;

    assign word_idx = paddr[ADDR_WIDTH-1:OFS];

    always_comb begin
        setup_err = (paddr[OFS-1:0] != '0) || (word_idx >= WIDX_W'(NUM_REGS));
`ifdef APB_REGFILE_SECURE_EN
        setup_err = setup_err || pprot[1];
`else
        setup_err = setup_err;
`endif
    end

    // Completion is qualified by the live psel/penable so the requester never sees
    // pready during setup or after it has withdrawn the transfer.
    assign pready  = (state == ACTIVE) && psel && penable && (cnt == 4'd0);
    assign pslverr = pready && err;
    assign prdata  = (pready && !wr && !err) ? regs[idx] : '0;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            idx    <= '0;
            wr     <= 1'b0;
            err    <= 1'b0;
            wdata  <= '0;
            strb   <= '0;
            reg_wr <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            reg_wr <= '0;
            case (state)
                IDLE: begin
                    // An access phase with no preceding setup is not a transfer.
                    if (psel && !penable) begin
                        idx   <= word_idx[IDX_W-1:0];
                        wr    <= pwrite;
                        err   <= setup_err;
                        wdata <= pwdata;
                        strb  <= pstrb;
                        cnt   <= 4'(WAIT_CYCLES);
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!psel) begin
                        // Requester abandoned the transfer: nothing is committed.
                        state <= IDLE;
                    end else if (penable) begin
                        if (cnt != 4'd0) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            state <= IDLE;
                            if (wr && !err) begin
                                for (int b = 0; b < STRB_W; b++) begin
                                    if (strb[b]) begin
                                        regs[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                                    end
                                end
                                // Pulses even for an all-zero strobe: the register was addressed.
                                reg_wr[idx] <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_q
        assign regs_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_apb_regfile.sv
// Randomized self-checking bench for apb_regfile with a queue-based scoreboard.
// Stimulus pushes the expected response of every transfer it starts; a monitor pops on pready.
// The reference model is a plain array of register words updated by byte strobes.

module tb_apb_regfile;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int WC = 1;
    localparam int SW = DW / 8;
    localparam int CW = NR * DW;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [2:0]    pprot;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic [CW-1:0] regs_q;
    logic [NR-1:0] reg_wr;

    apb_regfile #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .WAIT_CYCLES(WC)
    ) dut (
        .pclk   (pclk),
        .presetn(presetn),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .pstrb  (pstrb),
        .pprot  (pprot),
        .pready (pready),
        .prdata (prdata),
        .pslverr(pslverr),
        .regs_q (regs_q),
        .reg_wr (reg_wr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic          wr;
        logic          err;
        logic [DW-1:0] rd;
        int            idx;
        logic [CW-1:0] snap;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model [NR];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [CW-1:0] model_flat();
        logic [CW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    // ---------------- monitor ----------------
    logic          pend = 1'b0;
    logic [NR-1:0] pend_wr;
    logic [CW-1:0] pend_snap;

    always @(negedge pclk) begin
        if (!presetn) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("reg_wr_pulse", CW'(reg_wr), CW'(pend_wr));
                chk("regs_q", regs_q, pend_snap);
                pend = 1'b0;
            end else begin
                chk("reg_wr_quiet", CW'(reg_wr), '0);
            end
            chk("pready_qualified", CW'(pready & ~(psel & penable)), '0);
            if (pready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pready", CW'(pready), '0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("prdata", CW'(prdata), CW'(e.rd));
                    chk("pslverr", CW'(pslverr), CW'(e.err));
                    pend      = 1'b1;
                    pend_wr   = (e.wr && !e.err) ? NR'(1) << e.idx : '0;
                    pend_snap = e.snap;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_setup(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [SW-1:0] s, input logic [2:0] pr);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; pprot = pr;
    endtask

    task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic [2:0] pr);
        exp_t e;
        int   n;
        logic bad;
        bad = ((a % SW) != 0) || ((a / SW) >= NR);
`ifdef APB_REGFILE_SECURE_EN
        bad = bad || pr[1];
`endif
        e.wr  = wr;
        e.err = bad;
        e.idx = bad ? 0 : int'(a / SW);
        e.rd  = (!wr && !bad) ? model[e.idx] : '0;
        if (wr && !bad)
            for (int b = 0; b < SW; b++)
                if (s[b]) model[e.idx][b*8 +: 8] = d[b*8 +: 8];
        e.snap = model_flat();
        sb.push_back(e);

        drive_setup(wr, a, d, s, pr);
        @(negedge pclk);
        chk("pready_in_setup", CW'(pready), '0);
        @(posedge pclk); #1;
        penable = 1'b1;
        // Scrambling inputs during the access phase must not affect the transfer.
        pwrite = ~wr; paddr = $urandom; pwdata = $urandom; pstrb = SW'($urandom); pprot = 3'($urandom);
        n = 1;
        @(negedge pclk);
        while (!pready && n < 40) begin
            @(negedge pclk);
            n++;
        end
        chk("latency", CW'(n), CW'(WC + 1));
        if (!pready) void'(sb.pop_back());
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic abort_xfer(input logic wr, input logic [AW-1:0] a, input int k);
        drive_setup(wr, a, DW'($urandom), '1, 3'b000);
        @(posedge pclk); #1;
        if (k > 0) begin
            penable = 1'b1;
            repeat (k) begin @(posedge pclk); #1; end
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic idle(input int g);
        psel = 1'b0; penable = 1'b0;
        repeat (g) begin @(posedge pclk); #1; end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)      return AW'($urandom_range(0, NR - 1) * SW);
        else if (r == 7) return AW'($urandom_range(NR, NR + 3) * SW);
        else if (r == 8) return AW'($urandom) & ~AW'(SW - 1);
        else             return AW'($urandom_range(0, NR - 1) * SW + $urandom_range(1, SW - 1));
    endfunction

    initial begin
        for (int i = 0; i < NR; i++) model[i] = '0;
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_pready", CW'(pready), '0);
        chk("rst_prdata", CW'(prdata), '0);
        chk("rst_pslverr", CW'(pslverr), '0);
        chk("rst_reg_wr", CW'(reg_wr), '0);
        chk("rst_regs_q", regs_q, '0);
        presetn = 1'b1;
        idle(2);

        // Directed cases
        xfer(1'b0, 32'h0C, '0, '0, 3'b000);
        xfer(1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 3'b000);
        xfer(1'b0, 32'h08, '0, '0, 3'b000);
        xfer(1'b1, 32'h08, 32'h11223344, 4'b0101, 3'b000);
        xfer(1'b0, 32'h08, '0, '0, 3'b000);
        chk("partial_write_model", CW'(model[2]), CW'(32'hDE22BE44));
        xfer(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 3'b000);
        xfer(1'b1, 32'h05, 32'hCAFEF00D, 4'hF, 3'b000);
        xfer(1'b1, 32'h00, 32'h5, 4'hF, 3'b000);
        xfer(1'b0, 32'h00, '0, '0, 3'b000);
        xfer(1'b1, 32'h04, 32'hA5A5A5A5, 4'hF, 3'b010);
        xfer(1'b1, 32'h04, 32'hA5A5A5A5, 4'hF, 3'b000);
        xfer(1'b1, 32'h1C, 32'h12345678, 4'h0, 3'b000);
        xfer(1'b0, 32'h04, '0, '0, 3'b000);
        abort_xfer(1'b1, 32'h0C, 0);
        abort_xfer(1'b1, 32'h0C, WC);
        xfer(1'b0, 32'h0C, '0, '0, 3'b000);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                abort_xfer(1'($urandom), rand_addr(), $urandom_range(0, WC));
            end else if (r == 1) begin
                psel = 1'b1; penable = 1'b1; paddr = '0; pwrite = 1'b1; pwdata = $urandom;
                @(posedge pclk); #1;
                psel = 1'b0; penable = 1'b0;
            end else begin
                xfer(1'($urandom), rand_addr(), DW'($urandom), SW'($urandom), 3'($urandom));
            end
            idle($urandom_range(0, 2));
        end

        // Reset during an in-flight write
        drive_setup(1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, 3'b000);
        @(posedge pclk); #1;
        penable = 1'b1;
        #2 presetn = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        #1;
        chk("midrst_pready", CW'(pready), '0);
        chk("midrst_regs_q", regs_q, '0);
        chk("midrst_prdata", CW'(prdata), '0);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk); #1;
        xfer(1'b0, 32'h10, '0, '0, 3'b000);
        xfer(1'b1, 32'h10, 32'h0BADCAFE, 4'hF, 3'b000);
        xfer(1'b0, 32'h10, '0, '0, 3'b000);

        repeat (4) @(posedge pclk);
        #1;
        chk("scoreboard_drained", CW'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
